// File: rtl/spi_flash_responder_pkg.sv
// Shared constants, state encoding and sizing helpers for the SPI flash responder.
package spi_flash_responder_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_RDID = 8'h9F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_IGNORE
    } state_e;

    // Number of address bytes sent by the initiator for a given address width.
    function automatic int unsigned addr_bytes(input int unsigned addr_w);
        return (addr_w + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the local memory read port of the flash responder.
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        input  mem_rdata,
        output spi_miso,
        output spi_miso_oe,
        output mem_rd_en,
        output mem_addr,
        output busy
    );

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        output mem_rdata,
        input  spi_miso,
        input  spi_miso_oe,
        input  mem_rd_en,
        input  mem_addr,
        input  busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third stage for rise/fall detection; idles high.
module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];
    assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 boot-flash emulator: READ (0x03) streams bytes from a local memory port.
// Optional feature macro SPI_RESP_JEDEC_ID_EN adds the 0x9F JEDEC ID response.
module spi_flash_responder
    import spi_flash_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
`ifdef SPI_RESP_JEDEC_ID_EN
    ,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
`endif
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_flash_responder_if.slave bus
);

    localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_W);
    localparam int unsigned ADDR_SR_W  = ADDR_BYTES * 8;
    localparam int unsigned CNT_W      = $clog2(ADDR_SR_W);

    logic sclk_rise_c;
    logic sclk_fall_c;
    logic cs_rise_c;
    logic cs_fall_c;
    logic mosi_meta;
    logic mosi_s;

    state_e state;
    state_e state_d;

    logic [CNT_W-1:0]     bit_cnt,    bit_cnt_d;
    logic [ADDR_SR_W-2:0] rx_sr,      rx_sr_d;
    logic [7:0]           tx_sr,      tx_sr_d;
    logic [2:0]           tx_cnt,     tx_cnt_d;
    logic                 rd_pend,    rd_pend_d;
    logic                 miso_q,     miso_d;
    logic                 oe_q,       oe_d;
    logic                 rd_en_q,    rd_en_d;
    logic                 busy_q,     busy_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
`ifdef SPI_RESP_JEDEC_ID_EN
    logic [23:0]          id_sr,      id_sr_d;
`endif

    logic [7:0]           cmd_byte_c;
    logic [ADDR_SR_W-1:0] addr_full_c;
    logic                 last_cmd_bit_c;
    logic                 last_addr_bit_c;
    logic                 cs_abort_c;

    spi_sync_edge u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (bus.spi_sclk),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_sync_edge u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (bus.spi_cs_n),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    // MOSI is only sampled on SCLK rises, so a plain 2-FF synchroniser suffices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b1;
            mosi_s    <= 1'b1;
        end else begin
            mosi_meta <= bus.spi_mosi;
            mosi_s    <= mosi_meta;
        end
    end

    assign cmd_byte_c      = {rx_sr[6:0], mosi_s};
    assign addr_full_c     = {rx_sr, mosi_s};
    assign last_cmd_bit_c  = (bit_cnt == CNT_W'(7));
    assign last_addr_bit_c = (bit_cnt == CNT_W'(ADDR_SR_W - 1));
    assign cs_abort_c      = cs_rise_c && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; CS release wins over any SCLK edge seen in the same cycle.
    always_comb begin
        state_d = state;
        if (cs_abort_c) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall_c) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (sclk_rise_c && last_cmd_bit_c) begin
                        case (cmd_byte_c)
                            CMD_READ: state_d = ST_ADDR;
`ifdef SPI_RESP_JEDEC_ID_EN
                            CMD_RDID: state_d = ST_ID;
`endif
                            default:  state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_c && last_addr_bit_c) state_d = ST_DATA;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output next values.
    always_comb begin
        bit_cnt_d  = bit_cnt;
        rx_sr_d    = rx_sr;
        tx_sr_d    = tx_sr;
        tx_cnt_d   = tx_cnt;
        rd_pend_d  = rd_en_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        rd_en_d    = 1'b0;
        busy_d     = busy_q;
        mem_addr_d = mem_addr_q;
`ifdef SPI_RESP_JEDEC_ID_EN
        id_sr_d    = id_sr;
`endif
        if (cs_abort_c) begin
            busy_d    = 1'b0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            rd_pend_d = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall_c) begin
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_c) begin
                        rx_sr_d   = {rx_sr[ADDR_SR_W-3:0], mosi_s};
                        bit_cnt_d = last_cmd_bit_c ? '0 : CNT_W'(bit_cnt + 1'b1);
`ifdef SPI_RESP_JEDEC_ID_EN
                        if (last_cmd_bit_c && (cmd_byte_c == CMD_RDID)) id_sr_d = JEDEC_ID;
`endif
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_c) begin
                        rx_sr_d   = {rx_sr[ADDR_SR_W-3:0], mosi_s};
                        bit_cnt_d = CNT_W'(bit_cnt + 1'b1);
                        if (last_addr_bit_c) begin
                            mem_addr_d = addr_full_c[ADDR_W-1:0];
                            rd_en_d    = 1'b1;
                            tx_cnt_d   = '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall_c) begin
                        miso_d   = tx_sr[7];
                        oe_d     = 1'b1;
                        tx_sr_d  = {tx_sr[6:0], 1'b0};
                        tx_cnt_d = 3'(tx_cnt + 1'b1);
                        // Last bit of the byte is out: prefetch the next one.
                        if (tx_cnt == 3'd7) begin
                            mem_addr_d = ADDR_W'(mem_addr_q + 1'b1);
                            rd_en_d    = 1'b1;
                        end
                    end
                    if (rd_pend) tx_sr_d = bus.mem_rdata;
                end
`ifdef SPI_RESP_JEDEC_ID_EN
                ST_ID: begin
                    if (sclk_fall_c) begin
                        miso_d  = id_sr[23];
                        oe_d    = 1'b1;
                        id_sr_d = {id_sr[22:0], 1'b0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            tx_cnt     <= '0;
            rd_pend    <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
`ifdef SPI_RESP_JEDEC_ID_EN
            id_sr      <= '0;
`endif
        end else begin
            bit_cnt    <= bit_cnt_d;
            rx_sr      <= rx_sr_d;
            tx_sr      <= tx_sr_d;
            tx_cnt     <= tx_cnt_d;
            rd_pend    <= rd_pend_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            rd_en_q    <= rd_en_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
`ifdef SPI_RESP_JEDEC_ID_EN
            id_sr      <= id_sr_d;
`endif
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.busy        = busy_q;

endmodule
